// File: rtl/product_acc_pkg.sv
// Shared types, widths and the accumulate rule for product_accumulator.
// ACC_SATURATE_EN (in the top) selects the clamping form of acc_add.
package product_acc_pkg;

    localparam int unsigned PROD_W    = 8;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned MAX_ACC_W = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Returns {clamped, sum}; sum is wrapped or clamped to acc_w bits.
    function automatic logic [MAX_ACC_W:0] acc_add(
        input logic [MAX_ACC_W-1:0] acc,
        input logic [PROD_W-1:0]    prod,
        input int unsigned          acc_w,
        input logic                 sat_en
    );
        logic [MAX_ACC_W:0] raw;
        logic [MAX_ACC_W:0] lim;
        logic [MAX_ACC_W:0] res;
        logic               clamp;
        raw   = {1'b0, acc} + (MAX_ACC_W + 1)'(prod);
        lim   = ((MAX_ACC_W + 1)'(1) << acc_w) - (MAX_ACC_W + 1)'(1);
        res   = raw & lim;
        clamp = 1'b0;
        if (sat_en && (raw > lim)) begin
            res   = lim;
            clamp = 1'b1;
        end
        return {clamp, res[MAX_ACC_W-1:0]};
    endfunction

endpackage

// File: rtl/product_accumulator_acc_adder.sv
// Combinational ACC_W-bit accumulate adder with optional saturation clamp.
module acc_adder
    import product_acc_pkg::*;
#(
    parameter int unsigned ACC_W  = 16,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum_c,
    output logic              clamp_c
);

    logic [MAX_ACC_W:0] res;
    logic               unused_res;

    always_comb begin
        res     = acc_add(MAX_ACC_W'(acc), prod, ACC_W, SAT_EN);
        sum_c   = ACC_W'(res);
        clamp_c = res[MAX_ACC_W];
    end

    // Upper result bits above ACC_W are always zero after masking.
    assign unused_res = ^res;

endmodule

// File: rtl/product_accumulator.sv
// Sums NUM_TERMS multiplier products per group and hands the total out on valid/ready.
// Define ACC_SATURATE_EN for a clamping add and the sticky sat_flag output.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned NUM_TERMS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        prod_in,
    input  logic              prod_done,
    input  logic              clear,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic              out_valid,
    output logic [7:0]        term_cnt,
    output logic              overrun,
    output logic              acc_busy
`ifdef ACC_SATURATE_EN
    ,
    output logic              sat_flag
`endif
);

`ifdef ACC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS);

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n, add_base, add_sum_c;
    logic [ACC_W-1:0]   sum_n;
    logic [CNT_W-1:0]   cnt_n, cnt_inc;
    logic               valid_n, ovr_n, busy_n, sat_q, sat_n, clamp_c;

    // An accept-cycle product starts a fresh group, so it adds onto zero.
    assign add_base = (state == HOLD) ? '0 : acc;
    assign cnt_inc  = CNT_W'(term_cnt + 1'b1);

    acc_adder #(.ACC_W(ACC_W), .SAT_EN(SAT_EN)) u_adder (
        .acc     (add_base),
        .prod    (prod_in),
        .sum_c   (add_sum_c),
        .clamp_c (clamp_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ACCUM;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (prod_done && (cnt_inc == LAST_CNT)) state_n = HOLD;
                HOLD:    if (out_ready && !(prod_done && (NUM_TERMS == 1))) state_n = ACCUM;
                default: state_n = ACCUM;
            endcase
        end
    end

    // Next values of the datapath registers and outputs.
    always_comb begin
        acc_n   = acc;
        cnt_n   = term_cnt;
        sum_n   = sum_out;
        valid_n = out_valid;
        ovr_n   = overrun;
        sat_n   = sat_q;
        if (clear) begin
            acc_n   = '0;
            cnt_n   = '0;
            valid_n = 1'b0;
            ovr_n   = 1'b0;
            sat_n   = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (prod_done) begin
                        acc_n = add_sum_c;
                        cnt_n = cnt_inc;
                        sat_n = sat_q | clamp_c;
                        if (cnt_inc == LAST_CNT) begin
                            sum_n   = add_sum_c;
                            valid_n = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_n = 1'b0;
                        acc_n   = '0;
                        cnt_n   = '0;
                        sat_n   = 1'b0;
                        if (prod_done) begin
                            acc_n = add_sum_c;
                            cnt_n = CNT_W'(1);
                            sat_n = clamp_c;
                            if (NUM_TERMS == 1) begin
                                sum_n   = add_sum_c;
                                valid_n = 1'b1;
                            end
                        end
                    end else if (prod_done) begin
                        ovr_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        busy_n = (state_n == ACCUM) && (cnt_n != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc       <= '0;
            term_cnt  <= '0;
            sum_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            acc_busy  <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            acc       <= acc_n;
            term_cnt  <= cnt_n;
            sum_out   <= sum_n;
            out_valid <= valid_n;
            overrun   <= ovr_n;
            acc_busy  <= busy_n;
            sat_q     <= sat_n;
        end
    end

`ifdef ACC_SATURATE_EN
    assign sat_flag = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three configurations driven in parallel and
// compared each cycle against a group-level model; honours ACC_SATURATE_EN.
module tb_product_accumulator;

`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  prod_in;
    logic        prod_done;
    logic        clear;
    logic        out_ready;

    logic [15:0] s0;
    logic [8:0]  s1;
    logic [11:0] s2;
    logic [7:0]  c0, c1, c2;
    logic [2:0]  v, ov, bz, sf;

    int checks = 0;
    int failures = 0;

    product_accumulator #(.ACC_W(16), .NUM_TERMS(4)) dut0 (
        .clk(clk), .reset(reset), .prod_in(prod_in), .prod_done(prod_done),
        .clear(clear), .out_ready(out_ready), .sum_out(s0), .out_valid(v[0]),
        .term_cnt(c0), .overrun(ov[0]), .acc_busy(bz[0])
`ifdef ACC_SATURATE_EN
        , .sat_flag(sf[0])
`endif
    );
    product_accumulator #(.ACC_W(9), .NUM_TERMS(4)) dut1 (
        .clk(clk), .reset(reset), .prod_in(prod_in), .prod_done(prod_done),
        .clear(clear), .out_ready(out_ready), .sum_out(s1), .out_valid(v[1]),
        .term_cnt(c1), .overrun(ov[1]), .acc_busy(bz[1])
`ifdef ACC_SATURATE_EN
        , .sat_flag(sf[1])
`endif
    );
    product_accumulator #(.ACC_W(12), .NUM_TERMS(1)) dut2 (
        .clk(clk), .reset(reset), .prod_in(prod_in), .prod_done(prod_done),
        .clear(clear), .out_ready(out_ready), .sum_out(s2), .out_valid(v[2]),
        .term_cnt(c2), .overrun(ov[2]), .acc_busy(bz[2])
`ifdef ACC_SATURATE_EN
        , .sat_flag(sf[2])
`endif
    );

`ifndef ACC_SATURATE_EN
    assign sf = 3'b000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int cnt;
        int sum;
        bit valid;
        bit ovr;
        bit sat;
        bit hold;
    } model_t;

    model_t m [3];

    function automatic int cfg_w(int i);
        case (i)
            0:       return 16;
            1:       return 9;
            default: return 12;
        endcase
    endfunction

    function automatic int cfg_t(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    // Adds a product under the wrap or clamp rule for instance i.
    function automatic int add_prod(int i, int base);
        int s;
        int lim;
        s   = base + int'(prod_in);
        lim = (1 << cfg_w(i)) - 1;
        if (s > lim) begin
            if (SAT) begin
                s = lim;
                m[i].sat = 1'b1;
            end else begin
                s = s % (lim + 1);
            end
        end
        return s;
    endfunction

    function automatic void model_step(int i);
        if (!reset) begin
            m[i] = '{acc: 0, cnt: 0, sum: 0, valid: 0, ovr: 0, sat: 0, hold: 0};
        end else if (clear) begin
            m[i].acc = 0; m[i].cnt = 0; m[i].valid = 0;
            m[i].ovr = 0; m[i].sat = 0; m[i].hold = 0;
        end else if (!m[i].hold) begin
            if (prod_done) begin
                m[i].acc = add_prod(i, m[i].acc);
                m[i].cnt++;
                if (m[i].cnt == cfg_t(i)) begin
                    m[i].hold = 1; m[i].valid = 1; m[i].sum = m[i].acc;
                end
            end
        end else if (out_ready) begin
            m[i].hold = 0; m[i].valid = 0; m[i].acc = 0; m[i].cnt = 0; m[i].sat = 0;
            if (prod_done) begin
                m[i].acc = add_prod(i, 0);
                m[i].cnt = 1;
                if (cfg_t(i) == 1) begin
                    m[i].hold = 1; m[i].valid = 1; m[i].sum = m[i].acc;
                end
            end
        end else if (prod_done) begin
            m[i].ovr = 1;
        end
    endfunction

    task automatic chk(string name, int i, logic [31:0] act, int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0d expected=%0d at %0t", name, i, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] act_sum(int i);
        case (i)
            0:       return 32'(s0);
            1:       return 32'(s1);
            default: return 32'(s2);
        endcase
    endfunction

    function automatic logic [31:0] act_cnt(int i);
        case (i)
            0:       return 32'(c0);
            1:       return 32'(c1);
            default: return 32'(c2);
        endcase
    endfunction

    // Advance one clock, update the model, then compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("sum_out",   i, act_sum(i), m[i].sum);
            chk("out_valid", i, 32'(v[i]),  int'(m[i].valid));
            chk("term_cnt",  i, act_cnt(i), m[i].cnt);
            chk("overrun",   i, 32'(ov[i]), int'(m[i].ovr));
            chk("acc_busy",  i, 32'(bz[i]), int'(!m[i].hold && m[i].cnt > 0));
            if (SAT) chk("sat_flag", i, 32'(sf[i]), int'(m[i].sat));
        end
    endtask

    task automatic drive(bit d, int p, bit r, bit c);
        prod_done = d;
        prod_in   = 8'(p);
        out_ready = r;
        clear     = c;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            m[i] = '{acc: 0, cnt: 0, sum: 0, valid: 0, ovr: 0, sat: 0, hold: 0};
        reset = 1'b0; prod_in = '0; prod_done = 1'b0; clear = 1'b0; out_ready = 1'b0;
        cycle();
        cycle();
        chk("rst_sum", 0, 32'(s0), 0);
        chk("rst_valid", 0, 32'(v[0]), 0);
        reset = 1'b1;

        // Basic group with consumer ready.
        drive(1, 15, 1, 0); drive(1, 20, 1, 0); drive(1, 30, 1, 0); drive(1, 225, 1, 0);
        chk("t1_sum", 0, 32'(s0), 290);
        chk("t1_valid", 0, 32'(v[0]), 1);
        drive(0, 0, 1, 0);
        chk("t1_cnt", 0, 32'(c0), 0);
        chk("t1_drop", 0, 32'(v[0]), 0);

        // Backpressure then a dropped product.
        drive(1, 1, 0, 0); drive(1, 2, 0, 0); drive(1, 3, 0, 0); drive(1, 4, 0, 0);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 0);
        drive(1, 7, 0, 0);
        chk("t2_ovr", 0, 32'(ov[0]), 1);
        chk("t2_sum", 0, 32'(s0), 10);
        drive(0, 0, 1, 0);
        chk("t2_cnt", 0, 32'(c0), 0);
        drive(0, 0, 0, 1);
        chk("t2_clr_ovr", 0, 32'(ov[0]), 0);

        // Accept collides with the next group's first product.
        drive(1, 5, 0, 0); drive(1, 5, 0, 0); drive(1, 5, 0, 0); drive(1, 5, 0, 0);
        drive(1, 9, 1, 0);
        chk("t3_cnt", 0, 32'(c0), 1);
        chk("t3_valid", 0, 32'(v[0]), 0);
        chk("t3_ovr", 0, 32'(ov[0]), 0);
        drive(1, 1, 0, 0); drive(1, 1, 0, 0); drive(1, 1, 1, 0);
        chk("t3_sum", 0, 32'(s0), 12);
        drive(0, 0, 1, 0);

        // clear discards a partial group and a same-cycle product.
        drive(1, 10, 1, 0); drive(1, 11, 1, 0);
        drive(1, 50, 1, 1);
        chk("t4_cnt", 0, 32'(c0), 0);
        chk("t4_valid", 0, 32'(v[0]), 0);
        drive(1, 1, 1, 0); drive(1, 1, 1, 0); drive(1, 1, 1, 0); drive(1, 1, 1, 0);
        chk("t4_sum", 0, 32'(s0), 4);
        drive(0, 0, 1, 0);

        // Overflow on the 9-bit instance.
        drive(1, 255, 0, 0); drive(1, 255, 0, 0); drive(1, 255, 0, 0); drive(1, 1, 0, 0);
        chk("t5_sum16", 0, 32'(s0), 766);
`ifdef ACC_SATURATE_EN
        chk("t5_sum9", 1, 32'(s1), 511);
        chk("t5_sat", 1, 32'(sf[1]), 1);
`else
        chk("t5_sum9", 1, 32'(s1), 254);
`endif
        // Reset in HOLD, then mid-group.
        reset = 1'b0; drive(0, 0, 0, 0); reset = 1'b1;
        chk("t6_valid", 0, 32'(v[0]), 0);
        chk("t6_sum", 0, 32'(s0), 0);
        drive(1, 40, 0, 0); drive(1, 40, 0, 0);
        reset = 1'b0; drive(0, 0, 0, 0); reset = 1'b1;
        chk("t6_cnt", 0, 32'(c0), 0);
        drive(1, 2, 1, 0); drive(1, 2, 1, 0); drive(1, 2, 1, 0); drive(1, 2, 1, 0);
        chk("t6_sum8", 0, 32'(s0), 8);
        drive(0, 0, 1, 0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) != 0);
            drive(($urandom_range(0, 99) < 55), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3));
        end
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
